// File: rtl/fetch_queue.sv
// fetch_queue: two-wide circular instruction buffer between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward valid_in straight to the outputs.
`default_nettype none

module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              valid_in,
  input  logic [1:0][WIDTH-1:0]   pc_in,
  input  logic [1:0][WIDTH-1:0]   instr_in,
  output logic                    ready_out,
  output logic [1:0]              valid_out,
  output logic [1:0][WIDTH-1:0]   pc_out,
  output logic [1:0][WIDTH-1:0]   instr_out,
  input  logic [1:0]              deq_cnt,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, head_p1;
  logic [CW-1:0]         count_q, count_d, avail;
  logic [WIDTH-1:0]      pc_mem    [DEPTH];
  logic [WIDTH-1:0]      instr_mem [DEPTH];

  logic [1:0][WIDTH-1:0] cpc, cinstr;
  logic [1:0]            enq, deq_req, deq, skip, wr_n;
  logic                  byp;
  logic [1:0]            wr_en;
  logic [1:0][PW-1:0]    wr_addr;
  logic [1:0][WIDTH-1:0] wr_pc, wr_instr;

  assign ready_out = (count_q <= CW'(DEPTH - 2));
  assign count     = count_q;

  // Compaction: the oldest valid slot always lands in compacted slot 0.
  assign cpc[0]    = valid_in[0] ? pc_in[0]    : pc_in[1];
  assign cpc[1]    = pc_in[1];
  assign cinstr[0] = valid_in[0] ? instr_in[0] : instr_in[1];
  assign cinstr[1] = instr_in[1];

  assign enq     = ready_out ? ({1'b0, valid_in[0]} + {1'b0, valid_in[1]}) : 2'd0;
  assign deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  // While bypassing, decode consumes compacted slots directly; only the rest is stored.
  assign avail = count_q + (byp ? CW'(enq) : '0);
  assign deq   = (CW'(deq_req) > avail) ? avail[1:0] : deq_req;
  assign skip  = byp ? deq : 2'd0;
  assign wr_n  = flush ? 2'd0 : (enq - skip);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_en[k]    = (2'(k) < wr_n);
      wr_addr[k]  = tail_q + PW'(k);
      wr_pc[k]    = cpc[skip[0] | 1'(k)];
      wr_instr[k] = cinstr[skip[0] | 1'(k)];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + (byp ? '0 : PW'(deq));
      tail_d  = tail_q + PW'(wr_n);
      count_d = count_q + CW'(wr_n) - (byp ? '0 : CW'(deq));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) begin
        pc_mem[wr_addr[k]]    <= wr_pc[k];
        instr_mem[wr_addr[k]] <= wr_instr[k];
      end
    end
  end

  assign head_p1 = head_q + PW'(1);

  always_comb begin
    valid_out    = {count_q >= CW'(2), count_q != '0};
    pc_out[0]    = pc_mem[head_q];
    pc_out[1]    = pc_mem[head_p1];
    instr_out[0] = instr_mem[head_q];
    instr_out[1] = instr_mem[head_p1];
    if (byp) begin
      valid_out = (enq == 2'd2) ? 2'b11 : ((enq == 2'd1) ? 2'b01 : 2'b00);
      pc_out    = cpc;
      instr_out = cinstr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model.
`default_nettype none

module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            valid_in;
  logic [1:0][WIDTH-1:0] pc_in;
  logic [1:0][WIDTH-1:0] instr_in;
  logic                  ready_out;
  logic [1:0]            valid_out;
  logic [1:0][WIDTH-1:0] pc_out;
  logic [1:0][WIDTH-1:0] instr_out;
  logic [1:0]            deq_cnt;
  logic                  flush;
  logic [3:0]            count;

  int n_assert = 0;
  int n_fail   = 0;

  // Each model entry is {pc, instr}; front of the queue is the oldest entry.
  logic [63:0] mq[$];

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .ready_out(ready_out), .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .deq_cnt(deq_cnt), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] dq, input logic fl);
    logic [63:0] cq[$];
    logic [63:0] view[$];
    int sz, d;
    bit rdy, byp;
    valid_in    = v;
    pc_in[0]    = p0;
    pc_in[1]    = p1;
    instr_in[0] = i0;
    instr_in[1] = i1;
    deq_cnt     = dq;
    flush       = fl;
    #1;
    sz = mq.size();
    if (v[0]) cq.push_back({p0, i0});
    if (v[1]) cq.push_back({p1, i1});
    rdy = (DEPTH - sz) >= 2;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    if (byp) view = cq;
    else     view = mq;
    chk("ready_out", 64'(ready_out), 64'(rdy));
    chk("count", 64'(count), 64'(sz));
    chk("valid_out", 64'(valid_out), 64'({view.size() >= 2, view.size() >= 1}));
    for (int s = 0; s < 2; s++) begin
      if (view.size() > s) begin
        chk($sformatf("pc_out[%0d]", s), 64'(pc_out[s]), 64'(view[s][63:32]));
        chk($sformatf("instr_out[%0d]", s), 64'(instr_out[s]), 64'(view[s][31:0]));
      end
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (!rdy) cq.delete();
      d = (dq == 2'd3) ? 2 : int'(dq);
      if (byp) begin
        if (d > cq.size()) d = cq.size();
        repeat (d) void'(cq.pop_front());
      end else begin
        if (d > sz) d = sz;
        repeat (d) void'(mq.pop_front());
      end
      foreach (cq[j]) mq.push_back(cq[j]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; valid_in = '0; pc_in = '0; instr_in = '0; deq_cnt = '0; flush = 1'b0;
    #1;
    chk("reset valid_out", 64'(valid_out), 64'(0));
    chk("reset ready_out", 64'(ready_out), 64'(1));
    chk("reset count", 64'(count), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Fill: four pairs fit, the fifth is dropped.
    for (int i = 0; i < 5; i++)
      cycle(2'b11, 32'(8 * i), 32'(8 * i + 4), $urandom, $urandom, 2'd0, 1'b0);
    idle();

    // Offset head to 3, refill, then drain two per cycle so head wraps from 7.
    repeat (3) cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0);
    cycle(2'b11, 32'h20, 32'h24, $urandom, $urandom, 2'd0, 1'b0);
    repeat (5) cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);

    // Clamp: count 1, deq_cnt 2 with a new pair arriving.
    cycle(2'b01, 32'h100, 32'h0, $urandom, $urandom, 2'd0, 1'b0);
    cycle(2'b11, 32'h200, 32'h204, $urandom, $urandom, 2'd2, 1'b0);
    idle();

    // Flush with count 5 and a simultaneous enqueue.
    cycle(2'b11, 32'h300, 32'h304, $urandom, $urandom, 2'd0, 1'b0);
    cycle(2'b01, 32'h308, 32'h0, $urandom, $urandom, 2'd0, 1'b0);
    cycle(2'b11, 32'h400, 32'h404, $urandom, $urandom, 2'd3, 1'b1);
    idle();

    // Asynchronous reset between edges with count 6.
    repeat (3) cycle(2'b11, $urandom, $urandom, $urandom, $urandom, 2'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async valid_out", 64'(valid_out), 64'(0));
    chk("async count", 64'(count), 64'(0));
    chk("async ready_out", 64'(ready_out), 64'(1));
    mq.delete();
    @(negedge clk);
    rst = 1'b1;

    // Empty queue, slot 1 only, consumed in the same cycle when bypass is built in.
    cycle(2'b10, 32'h500, 32'h504, $urandom, 32'h00000013, 2'd1, 1'b0);
    idle();

    for (int i = 0; i < 500; i++)
      cycle(2'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom),
            1'($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
